// File: rtl/cnt_chk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cnt_chk_pkg
// Description : Shared types and default constants for the counter checker.
// Revision    : 1.0 - initial release
// ============================================================================
package cnt_chk_pkg;

  // Default widths and loss-of-lock threshold
  localparam int c_err_w       = 8;
  localparam int c_wrap_w      = 8;
  localparam int c_loss_thresh = 3;

  // Value carried by the observed 4-bit step counter
  typedef logic [3:0] cnt_t;

  // Checker tracking states
  typedef enum logic [1:0] {
    ACQ   = 2'd0,
    TRACK = 2'd1,
    LOST  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/cnt_pred.sv
`default_nettype none
// ============================================================================
// Module      : cnt_pred
// Description : Combinational next-value predictor for the 4-bit up/down
//               step counter, plus a flag for a 15<->0 boundary crossing.
// Revision    : 1.0 - initial release
// ============================================================================
module cnt_pred
  import cnt_chk_pkg::*;
(
  input  logic [3:0] cnt,
  input  logic       step,
  input  logic       down,
  output logic [3:0] next,
  output logic       crossed
);

  logic [3:0] w_delta;

  // Step size in modulo-16 form: down steps become +15 / +14
  always_comb begin
    w_delta = 4'd1;
    case ({step, down})
      2'b00:   w_delta = 4'd1;
      2'b10:   w_delta = 4'd2;
      2'b01:   w_delta = 4'd15;
      2'b11:   w_delta = 4'd14;
      default: w_delta = 4'd1;
    endcase
  end

  assign next    = cnt + w_delta;
  // A wrap is seen as the result moving against the requested direction
  assign crossed = down ? (next > cnt) : (next < cnt);

endmodule
`default_nettype wire

// File: rtl/cnt_checker.sv
`default_nettype none
// ============================================================================
// Module      : cnt_checker
// Description : Tracks a 4-bit up/down step counter, flags mismatches against
//               the predicted value, reports wraps, and counts both with
//               saturating counters. Loses lock after a run of mismatches.
// Revision    : 1.0 - initial release
// ============================================================================
module cnt_checker
  import cnt_chk_pkg::*;
#(
  parameter int ERR_W       = c_err_w,
  parameter int WRAP_W      = c_wrap_w,
  parameter int LOSS_THRESH = c_loss_thresh
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [3:0]        cnt,
  input  logic              step,
  input  logic              down,
  input  logic              clr,
  output logic              locked,
  output logic [3:0]        exp,
  output logic              err,
  output logic              wrap,
  output logic              wrap_dn,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [WRAP_W-1:0] wrap_cnt
);

  localparam int c_miss_w = (LOSS_THRESH < 2) ? 1 : $clog2(LOSS_THRESH + 1);
  localparam logic [c_miss_w-1:0] c_loss = c_miss_w'(LOSS_THRESH);

  state_t              r_state;
  state_t              w_state_nxt;
  cnt_t                r_exp;
  cnt_t                w_exp_nxt;
  logic                r_locked;
  logic                r_err;
  logic                w_err_nxt;
  logic                r_wrap;
  logic                w_wrap_nxt;
  logic                r_wrap_dn;
  logic                w_wrap_dn_nxt;
  logic [ERR_W-1:0]    r_err_cnt;
  logic [ERR_W-1:0]    w_err_cnt_nxt;
  logic [WRAP_W-1:0]   r_wrap_cnt;
  logic [WRAP_W-1:0]   w_wrap_cnt_nxt;
  logic [c_miss_w-1:0] r_miss;
  logic [c_miss_w-1:0] w_miss_nxt;
  logic [c_miss_w-1:0] w_miss_inc;
  cnt_t                w_pred;
  logic                w_crossed;
  logic                w_mismatch;

  cnt_pred u_pred (
    .cnt     (cnt),
    .step    (step),
    .down    (down),
    .next    (w_pred),
    .crossed (w_crossed)
  );

  assign w_mismatch = (cnt != r_exp);
  assign w_miss_inc = r_miss + c_miss_w'(1);

  // State register; reset drops any prediction and restarts acquisition
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_state <= ACQ;
    else       r_state <= w_state_nxt;
  end

  // Next-state and datapath decisions; clr overrides every other event
  always_comb begin
    w_state_nxt    = r_state;
    w_exp_nxt      = r_exp;
    w_err_nxt      = 1'b0;
    w_wrap_nxt     = 1'b0;
    w_wrap_dn_nxt  = r_wrap_dn;
    w_err_cnt_nxt  = r_err_cnt;
    w_wrap_cnt_nxt = r_wrap_cnt;
    w_miss_nxt     = r_miss;
    if (clr) begin
      w_state_nxt    = ACQ;
      w_wrap_dn_nxt  = 1'b0;
      w_err_cnt_nxt  = '0;
      w_wrap_cnt_nxt = '0;
      w_miss_nxt     = '0;
    end else begin
      case (r_state)
        ACQ: begin
          w_exp_nxt   = w_pred;
          w_state_nxt = TRACK;
        end
        TRACK: begin
          // Always reseed from the observed value so one glitch costs one error
          w_exp_nxt = w_pred;
          if (w_mismatch) begin
            w_err_nxt = 1'b1;
            if (!(&r_err_cnt)) w_err_cnt_nxt = r_err_cnt + ERR_W'(1);
            if (w_miss_inc == c_loss) begin
              w_state_nxt = LOST;
              w_miss_nxt  = '0;
            end else begin
              w_miss_nxt = w_miss_inc;
            end
          end else begin
            w_miss_nxt = '0;
            if (w_crossed) begin
              w_wrap_nxt    = 1'b1;
              w_wrap_dn_nxt = down;
              if (!(&r_wrap_cnt)) w_wrap_cnt_nxt = r_wrap_cnt + WRAP_W'(1);
            end
          end
        end
        LOST: begin
          w_state_nxt = ACQ;
        end
        default: begin
          w_state_nxt = ACQ;
        end
      endcase
    end
  end

  // Registered outputs and tracking datapath
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_exp      <= '0;
      r_locked   <= 1'b0;
      r_err      <= 1'b0;
      r_wrap     <= 1'b0;
      r_wrap_dn  <= 1'b0;
      r_err_cnt  <= '0;
      r_wrap_cnt <= '0;
      r_miss     <= '0;
    end else begin
      r_exp      <= w_exp_nxt;
      r_locked   <= (w_state_nxt == TRACK);
      r_err      <= w_err_nxt;
      r_wrap     <= w_wrap_nxt;
      r_wrap_dn  <= w_wrap_dn_nxt;
      r_err_cnt  <= w_err_cnt_nxt;
      r_wrap_cnt <= w_wrap_cnt_nxt;
      r_miss     <= w_miss_nxt;
    end
  end

  assign locked   = r_locked;
  assign exp      = r_exp;
  assign err      = r_err;
  assign wrap     = r_wrap;
  assign wrap_dn  = r_wrap_dn;
  assign err_cnt  = r_err_cnt;
  assign wrap_cnt = r_wrap_cnt;

endmodule
`default_nettype wire

// File: doc/cnt_checker.md
CNT_CHECKER -- requirements
Module: cnt_checker

Interface
REQ-001 The module SHALL have these parameters (name, default, meaning): ERR_W, 8, width of the saturating error counter; WRAP_W, 8, width of the saturating wrap counter; LOSS_THRESH, 3, consecutive mismatches that cause loss of lock.
REQ-002 The module SHALL have these ports (name, direction, width, meaning), with one clock and an asynchronous active-low reset:
- clk  input  1  sole clock; rising edge.
- nrst  input  1  asynchronous active-low reset.
- cnt  input  4  observed output of the 4-bit up/down step counter.
- step  input  1  step control applied to the counter at the same edge: 0 = ±1, 1 = ±2.
- down  input  1  direction control applied to the counter at the same edge: 0 = up, 1 = down.
- clr  input  1  synchronous clear of counters and lock.
- locked  output  1  predictor tracking the counter.
- exp  output  4  value predicted for cnt in the current cycle.
- err  output  1  one-cycle pulse: mismatch detected.
- wrap  output  1  one-cycle pulse: matched transition crossed 15↔0.
- wrap_dn  output  1  direction of the last wrap (1 = down); held until the next wrap.
- err_cnt  output  ERR_W  saturating mismatch count.
- wrap_cnt  output  WRAP_W  saturating wrap count.

Function
REQ-003 The prediction SHALL be next = (cnt + d) mod 16, where d = +1 for step=0,down=0; +2 for 1,0; −1 (i.e. +15) for 0,1; −2 (i.e. +14) for 1,1. Operands are sampled at the same rising edge.
REQ-004 The state machine SHALL have these states:
- ACQ: reset state.
- TRACK
- LOST
REQ-005 In ACQ, at each edge: exp <= next(cnt, step, down), then go to TRACK; no compare; err=0.
REQ-006 In TRACK, at each edge, cnt SHALL be compared with exp:
- match: exp <= next(cnt); miss run cleared.
- mismatch: err=1 on the following cycle; err_cnt incremented; miss run incremented; exp <= next(cnt) (reseed from the observed value).
REQ-007 When the miss run reaches LOSS_THRESH in TRACK, the FSM SHALL go to LOST and clear the miss run. LOST SHALL last one cycle without compare, then go to ACQ.
REQ-008 locked SHALL be 1 only in TRACK, and SHALL be a registered output.
REQ-009 On a match in TRACK, wrap SHALL pulse on the following cycle in these cases:
- down=0 and next < cnt: wrap_dn <= 0.
- down=1 and next > cnt: wrap_dn <= 1.
In both cases wrap_cnt is incremented. With step=1, bit 0 is preserved, so 14→0 and 15→1 count as wraps.
REQ-010 err_cnt and wrap_cnt SHALL saturate at all-ones and never roll over.
REQ-011 clr=1 at an edge SHALL:
- zero err_cnt, wrap_cnt, wrap_dn and the miss run;
- force ACQ;
- suppress err and wrap for that edge.
clr has priority over all other events.
REQ-012 A mismatch and a wrap SHALL never both be reported for the same edge; a mismatch suppresses wrap.
REQ-013 All outputs SHALL be registered; latency from the sampling edge to err/wrap is 1 cycle.

Reset
REQ-014 When nrst=0, the following SHALL hold, asynchronously and independent of clk:
- state = ACQ.
- exp = 0, locked = 0, err = 0, wrap = 0, wrap_dn = 0.
- err_cnt = 0, wrap_cnt = 0, miss run = 0.
REQ-015 Reset assertion mid-TRACK SHALL discard the prediction. The first edge after release SHALL be an ACQ edge.

Structure
REQ-016 A shared package cnt_chk_pkg SHALL hold:
- the state enum (ACQ, TRACK, LOST);
- default constants for ERR_W, WRAP_W and LOSS_THRESH;
- the 4-bit count typedef.
REQ-017 The prediction of REQ-003 and the wrap-crossing flag SHALL be a purely combinational sub-module cnt_pred, with ports cnt, step, down → next, crossed.

Verification
REQ-018 Reset, then cnt follows 0,1,2,…,15,0 with step=0,down=0 → locked=1 from the second edge; wrap=1 exactly once (after the 15→0 edge); wrap_dn=0; wrap_cnt=1; err_cnt=0.
REQ-019 step=1,down=1 from cnt=3: sequence 3,1,15,13 → wrap at 1→15 with wrap_dn=1; no err.
REQ-020 In TRACK with exp=6, inject cnt=9 once, then 10,11 (step=0,down=0) → exactly one err pulse; err_cnt=1; locked stays 1.
REQ-021 Inject 3 consecutive mismatching values → err pulses 3 times; err_cnt=3; locked=0 for 2 cycles (LOST, ACQ); then locked=1 again.
REQ-022 With ERR_W=2, force 5 isolated mismatches → err_cnt holds at 3. Then clr=1 for one edge → err_cnt=0, wrap_cnt=0, locked=0 on the next cycle.
REQ-023 Assert nrst=0 between clock edges while in TRACK → all outputs reach their reset values before the next edge.
